// File: rtl/word_block_packer.sv
// Word-to-block packer: gathers NWORDS input words into one BSIZE-bit block and hands it
// to a block consumer through a one-deep output register, with flush of partial blocks.
module word_block_packer #(
    parameter int WSIZE     = 32,
    parameter int NWORDS    = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int BSIZE    = WSIZE * NWORDS,
    localparam int CW       = $clog2(NWORDS) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WSIZE-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             flush,
    output logic [BSIZE-1:0] block_out,
    output logic [CW-1:0]    block_count,
    output logic             block_valid,
    input  logic             block_ready
);

    localparam int            IW   = CW - 1;
    localparam logic [CW-1:0] FULL = CW'(NWORDS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [WSIZE-1:0] acc_q [NWORDS];
    logic [WSIZE-1:0] acc_d [NWORDS];
    logic [CW-1:0]    fcnt_q, fcnt_d;
    logic [CW-1:0]    ocount_q, ocount_d;
    logic             flush_pend_q, flush_pend_d;
    logic             ovalid_q, ovalid_d;
    logic [BSIZE-1:0] obuf_q, obuf_d;
    logic [BSIZE-1:0] packed_acc;
    logic             accept;
    logic             xfer;

    // Input side: valid/ready, a word moves when word_valid && word_ready at posedge.
    // Output side: valid/ready, a block moves when block_valid && block_ready at posedge.
    assign word_ready = (fcnt_q != FULL) && !flush_pend_q;
    assign accept     = word_valid && word_ready;
    // Accept and transfer are mutually exclusive: a transfer needs word_ready low.
    assign xfer       = ((fcnt_q == FULL) || flush_pend_q) && (!ovalid_q || block_ready);

    always_comb begin
        packed_acc = '0;
        for (int i = 0; i < NWORDS; i++) begin
            packed_acc[(MSB_FIRST ? (NWORDS - 1 - i) : i) * WSIZE +: WSIZE] = acc_q[i];
        end
    end

    always_comb begin
        acc_d        = acc_q;
        fcnt_d       = fcnt_q;
        flush_pend_d = flush_pend_q;
        obuf_d       = obuf_q;
        ocount_d     = ocount_q;
        ovalid_d     = ovalid_q;

        if (accept) begin
            acc_d[fcnt_q[IW-1:0]] = word_in;
            fcnt_d                = fcnt_q + ONE;
        end

        // An empty accumulator ignores flush so no zero-word block is ever produced.
        if (flush && ((fcnt_q != '0) || accept)) begin
            flush_pend_d = 1'b1;
        end

        if (xfer) begin
            obuf_d       = packed_acc;
            ocount_d     = fcnt_q;
            ovalid_d     = 1'b1;
            fcnt_d       = '0;
            flush_pend_d = 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                acc_d[i] = '0;
            end
        end else if (ovalid_q && block_ready) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                acc_q[i] <= '0;
            end
            fcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            obuf_q       <= '0;
            ocount_q     <= '0;
            ovalid_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                acc_q[i] <= acc_d[i];
            end
            fcnt_q       <= fcnt_d;
            flush_pend_q <= flush_pend_d;
            obuf_q       <= obuf_d;
            ocount_q     <= ocount_d;
            ovalid_q     <= ovalid_d;
        end
    end

    assign block_out   = obuf_q;
    assign block_count = ocount_q;
    assign block_valid = ovalid_q;

endmodule
